recurrent_lif_array: RTL and testbench

RECURRENT_LIF_ARRAY -- requirements
Module: recurrent_lif_array

---
 rtl/recurrent_lif_array.sv | 124 ++++++++++++
 tb/tb_recurrent_lif_array.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recurrent_lif_array.sv
// ============================================================================
// Module   : recurrent_lif_array
// Purpose  : N leaky integrate-and-fire neurons with delayed self/ring feedback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module recurrent_lif_array #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int RW   = 6,
  parameter int DMAX = 4,
  localparam int DW  = $clog2(DMAX + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [N*W-1:0] external_input_current,
  input  logic [W-1:0]   threshold,
  input  logic [W-1:0]   leak,
  input  logic [W-1:0]   scale_factor,
  input  logic [RW-1:0]  refractory_period,
  input  logic [DW-1:0]  feedback_delay,
  input  logic [1:0]     feedback_mode,
  output logic [N-1:0]   spike
);

  localparam logic [DW-1:0] c_DMAX   = DW'(DMAX);
  localparam logic [1:0]    c_M_SELF = 2'd1;
  localparam logic [1:0]    c_M_RING = 2'd2;

  logic [W-1:0]  r_v [N];
  logic [RW-1:0] r_r [N];
  logic [N-1:0]  r_spike;
  // r_hist[k] holds every channel's spike flag from k enabled edges ago
  logic [N-1:0]  r_hist [1:DMAX];

  logic [DW-1:0] w_delay;
  logic [N-1:0]  w_tap;
  logic [W-1:0]  w_v_nxt [N];
  logic [RW-1:0] w_r_nxt [N];
  logic [N-1:0]  w_s_nxt;

  assign w_delay = (feedback_delay > c_DMAX) ? c_DMAX : feedback_delay;

  // Delay 0 taps the live spike register; deeper taps come from history
  always_comb begin
    w_tap = r_spike;
    for (int k = 1; k <= DMAX; k++) begin
      if (w_delay == DW'(k)) begin
        w_tap = r_hist[k];
      end
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_ch
      localparam int c_PREV = (i == 0) ? (N - 1) : (i - 1);

      logic         w_src;
      logic [W-1:0] w_ext;
      logic [W-1:0] w_fb;
      logic [W:0]   w_isum;
      logic [W-1:0] w_cur;
      logic [W:0]   w_psum;
      logic [W-1:0] w_psat;
      logic [W-1:0] w_p;
      logic         w_fire;

      assign w_src  = (feedback_mode == c_M_SELF) ? w_tap[i]      :
                      (feedback_mode == c_M_RING) ? w_tap[c_PREV] : 1'b0;
      assign w_ext  = external_input_current[i*W +: W];
      assign w_fb   = w_src ? scale_factor : '0;
      assign w_isum = {1'b0, w_ext} + {1'b0, w_fb};
      assign w_cur  = w_isum[W] ? '1 : w_isum[W-1:0];
      assign w_psum = {1'b0, r_v[i]} + {1'b0, w_cur};
      assign w_psat = w_psum[W] ? '1 : w_psum[W-1:0];
      assign w_p    = (w_psat > leak) ? (w_psat - leak) : '0;
      assign w_fire = (w_p >= threshold);

      always_comb begin
        w_v_nxt[i] = '0;
        w_r_nxt[i] = '0;
        w_s_nxt[i] = 1'b0;
        if (r_r[i] != '0) begin
          w_r_nxt[i] = r_r[i] - RW'(1);
        end else if (w_fire) begin
          w_s_nxt[i] = 1'b1;
          w_r_nxt[i] = refractory_period;
        end else begin
          w_v_nxt[i] = w_p;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_spike <= '0;
      for (int i = 0; i < N; i++) begin
        r_v[i] <= '0;
        r_r[i] <= '0;
      end
      for (int k = 1; k <= DMAX; k++) begin
        r_hist[k] <= '0;
      end
    end else if (enable) begin
      r_spike   <= w_s_nxt;
      r_hist[1] <= r_spike;
      for (int k = 2; k <= DMAX; k++) begin
        r_hist[k] <= r_hist[k-1];
      end
      for (int i = 0; i < N; i++) begin
        r_v[i] <= w_v_nxt[i];
        r_r[i] <= w_r_nxt[i];
      end
    end
  end

  assign spike = r_spike;

endmodule

`default_nettype wire

// File: tb/tb_recurrent_lif_array.sv
// ============================================================================
// Module   : tb_recurrent_lif_array
// Purpose  : Scoreboard bench for recurrent_lif_array against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_recurrent_lif_array;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int RW   = 6;
  localparam int DMAX = 4;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [N*W-1:0] external_input_current;
  logic [W-1:0]   threshold;
  logic [W-1:0]   leak;
  logic [W-1:0]   scale_factor;
  logic [RW-1:0]  refractory_period;
  logic [DW-1:0]  feedback_delay;
  logic [1:0]     feedback_mode;
  logic [N-1:0]   spike;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  logic [N-1:0] sb_q[$];

  // Reference state: membrane, refractory count, spike, and spike history
  int mV[N];
  int mR[N];
  int mS[N];
  int mH[N][DMAX+1];

  recurrent_lif_array #(.N(N), .W(W), .RW(RW), .DMAX(DMAX)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .external_input_current (external_input_current),
    .threshold              (threshold),
    .leak                   (leak),
    .scale_factor           (scale_factor),
    .refractory_period      (refractory_period),
    .feedback_delay         (feedback_delay),
    .feedback_mode          (feedback_mode),
    .spike                  (spike)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int nV[N];
    int nR[N];
    int nS[N];
    int d, src, fb, cur, p, hbit;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mV[i] = 0; mR[i] = 0; mS[i] = 0;
        for (int k = 0; k <= DMAX; k++) mH[i][k] = 0;
      end
      return;
    end
    if (!enable) return;
    d = (int'(feedback_delay) > DMAX) ? DMAX : int'(feedback_delay);
    for (int i = 0; i < N; i++) begin
      if (feedback_mode == 2'd1)      src = i;
      else if (feedback_mode == 2'd2) src = (i + N - 1) % N;
      else                            src = -1;
      fb = 0;
      if (src >= 0) begin
        hbit = (d == 0) ? mS[src] : mH[src][d];
        if (hbit != 0) fb = int'(scale_factor);
      end
      cur = int'(external_input_current[i*W +: W]) + fb;
      if (cur > MAXV) cur = MAXV;
      if (mR[i] > 0) begin
        nR[i] = mR[i] - 1; nV[i] = 0; nS[i] = 0;
      end else begin
        p = mV[i] + cur;
        if (p > MAXV) p = MAXV;
        p = p - int'(leak);
        if (p < 0) p = 0;
        if (p >= int'(threshold)) begin
          nS[i] = 1; nV[i] = 0; nR[i] = int'(refractory_period);
        end else begin
          nS[i] = 0; nV[i] = p; nR[i] = 0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int k = DMAX; k >= 2; k--) mH[i][k] = mH[i][k-1];
      mH[i][1] = mS[i];
      mV[i] = nV[i]; mR[i] = nR[i]; mS[i] = nS[i];
    end
  endtask

  function automatic logic [N-1:0] model_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (mS[i] != 0);
    return v;
  endfunction

  // Inputs are set after a negedge; one call covers one rising edge
  task automatic cycle();
    model_step();
    sb_q.push_back(model_vec());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %b expected %b", name, edge_no, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [N-1:0] e;
    #1;
    edge_no++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (spike !== e) begin
        errors++;
        $display("FAIL sb_spike edge %0d: got %b expected %b", edge_no, spike, e);
      end
    end
  end

  task automatic set_ext(input int e0, input int e1, input int e2, input int e3);
    external_input_current = {W'(e3), W'(e2), W'(e1), W'(e0)};
  endtask

  task automatic cfg(input int th, input int lk, input int sc, input int rf,
                     input int dl, input int md);
    threshold = W'(th); leak = W'(lk); scale_factor = W'(sc);
    refractory_period = RW'(rf); feedback_delay = DW'(dl); feedback_mode = 2'(md);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0]  seq6;
    logic [8:0]  seq9;
    logic [4:0]  seq5;
    reset = 1'b1;
    enable = 1'b1;
    set_ext(17, 99, 200, 3);
    cfg(7, 2, 40, 3, 1, 2);
    @(negedge clk);

    // Reset with arbitrary inputs
    do_reset();
    chk("reset_spike", spike, 4'b0000);

    // Basic integrate, no leak: period-2 spiking
    cfg(100, 0, 0, 0, 0, 0);
    set_ext(50, 0, 0, 0);
    seq6 = 6'b101010;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("integrate", spike, {3'b000, seq6[k]});
    end

    // Leak 10: 40, 80, then spike on edge 3
    do_reset();
    cfg(100, 10, 0, 0, 0, 0);
    seq6 = 6'b100100;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("leak", spike, {3'b000, seq6[k]});
    end

    // Saturation with immediate self feedback
    do_reset();
    cfg(255, 0, 100, 0, 0, 1);
    set_ext(200, 0, 0, 0);
    seq5 = 5'b11110;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("self_fb", spike, {3'b000, seq5[k]});
    end

    // Refractory period 3
    do_reset();
    cfg(10, 0, 0, 3, 0, 0);
    set_ext(255, 0, 0, 0);
    seq9 = 9'b100010001;
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk("refractory", spike, {3'b000, seq9[k]});
    end

    // Ring propagation with delay 2
    do_reset();
    cfg(200, 0, 250, 20, 2, 2);
    set_ext(255, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == 1)       chk("ring_d2", spike, 4'b0001);
      else if (k == 4)  chk("ring_d2", spike, 4'b0010);
      else if (k == 7)  chk("ring_d2", spike, 4'b0100);
      else if (k == 10) chk("ring_d2", spike, 4'b1000);
      else              chk("ring_d2", spike, 4'b0000);
    end

    // Delay 7 clamps to 4: next hop lands on edge 6
    do_reset();
    cfg(200, 0, 250, 20, 7, 2);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k == 1)      chk("ring_d7", spike, 4'b0001);
      else if (k == 6) chk("ring_d7", spike, 4'b0010);
      else             chk("ring_d7", spike, 4'b0000);
    end

    // Freeze, resume, and reset mid-refractory
    do_reset();
    cfg(100, 0, 0, 0, 0, 0);
    set_ext(50, 0, 0, 0);
    cycle();
    chk("freeze_pre", spike, 4'b0000);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("freeze_hold", spike, 4'b0000);
    end
    enable = 1'b1;
    refractory_period = RW'(5);
    cycle();
    chk("freeze_resume", spike, 4'b0001);
    cycle();
    chk("in_refractory", spike, 4'b0000);
    do_reset();
    chk("reset_mid_refr", spike, 4'b0000);
    cycle();
    chk("post_reset_int", spike, 4'b0000);
    cycle();
    chk("post_reset_fire", spike, 4'b0001);

    // Randomized traffic, scoreboard only
    for (int c = 0; c < 400; c++) begin
      if (c % 8 == 0)
        cfg($urandom_range(0, 220), $urandom_range(0, 30), $urandom_range(0, 255),
            $urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 3));
      set_ext($urandom_range(0, 255), $urandom_range(0, 120),
              $urandom_range(0, 60), $urandom_range(0, 255));
      enable = ($urandom_range(0, 99) < 85);
      reset  = ($urandom_range(0, 59) == 0);
      cycle();
    end
    reset = 1'b0;
    enable = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
